// File: rtl/cmd_host_arbiter.sv
// rtl/cmd_host_arbiter.sv - round-robin arbiter sharing one command-bus host port
// between NUM_REQ requesters, with its own ack timeout.
module cmd_host_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int HOST_ADDR_BITS   = 32,
    parameter int HOST_DATA_BITS   = 32,
    parameter int ACK_TIMEOUT_CLKS = 64,
    parameter logic [HOST_DATA_BITS-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic                               i_sysclk,
    input  logic                               i_srst,
    input  logic [NUM_REQ-1:0]                 i_req_sel,
    input  logic [NUM_REQ-1:0]                 i_req_rd_wr_n,
    input  logic [NUM_REQ*HOST_ADDR_BITS-1:0]  i_req_byte_addr,
    input  logic [NUM_REQ*HOST_DATA_BITS-1:0]  i_req_wdata,
    output logic [NUM_REQ-1:0]                 o_req_busy,
    output logic [NUM_REQ-1:0]                 o_req_ack,
    output logic [NUM_REQ-1:0]                 o_req_timeout,
    output logic [HOST_DATA_BITS-1:0]          o_req_rdata,
    output logic                               o_host_sel,
    output logic                               o_host_rd_wr_n,
    output logic [HOST_ADDR_BITS-1:0]          o_host_byte_addr,
    output logic [HOST_DATA_BITS-1:0]          o_host_wdata,
    input  logic                               i_host_ack,
    input  logic [HOST_DATA_BITS-1:0]          i_host_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT_CLKS - 1);

    typedef enum logic [0:0] {S_IDLE, S_WAIT_ACK} state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]        busy_q, busy_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      host_sel_q, host_sel_d;
    logic                      host_rd_wr_n_q, host_rd_wr_n_d;
    logic [HOST_ADDR_BITS-1:0] host_addr_q, host_addr_d;
    logic [HOST_DATA_BITS-1:0] host_wdata_q, host_wdata_d;
    logic [NUM_REQ-1:0]        req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]        req_timeout_q, req_timeout_d;
    logic [HOST_DATA_BITS-1:0] req_rdata_q, req_rdata_d;

    logic                      hold_rd_q    [NUM_REQ];
    logic [HOST_ADDR_BITS-1:0] hold_addr_q  [NUM_REQ];
    logic [HOST_DATA_BITS-1:0] hold_wdata_q [NUM_REQ];

    logic                      found;
    logic [IDX_W-1:0]          pick;
    logic [IDX_W-1:0]          cand;

    // Holding registers only load while their requester is idle, so a
    // repeated pulse never disturbs a pending or in-flight transaction.
    always_ff @(posedge i_sysclk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_sel[k] && !busy_q[k]) begin
                hold_rd_q[k]    <= i_req_rd_wr_n[k];
                hold_addr_q[k]  <= i_req_byte_addr[k*HOST_ADDR_BITS +: HOST_ADDR_BITS];
                hold_wdata_q[k] <= i_req_wdata[k*HOST_DATA_BITS +: HOST_DATA_BITS];
            end
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && busy_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        cnt_d          = cnt_q;
        host_sel_d     = 1'b0;
        host_rd_wr_n_d = host_rd_wr_n_q;
        host_addr_d    = host_addr_q;
        host_wdata_d   = host_wdata_q;
        req_ack_d      = '0;
        req_timeout_d  = '0;
        req_rdata_d    = req_rdata_q;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_sel[k] && !busy_q[k]) begin
                busy_d[k] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    host_sel_d     = 1'b1;
                    host_rd_wr_n_d = hold_rd_q[pick];
                    host_addr_d    = hold_addr_q[pick];
                    host_wdata_d   = hold_wdata_q[pick];
                    grant_d        = pick;
                    cnt_d          = '0;
                    state_d        = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real ack on the terminal-count cycle wins over the timeout.
                if (i_host_ack || cnt_q == CNT_LAST) begin
                    req_ack_d[grant_q]     = 1'b1;
                    req_timeout_d[grant_q] = !i_host_ack;
                    req_rdata_d            = i_host_ack ? i_host_rdata : TIMEOUT_RDATA;
                    busy_d[grant_q]        = 1'b0;
                    ptr_d                  = IDX_W'((int'(grant_q) + 1) % NUM_REQ);
                    cnt_d                  = '0;
                    state_d                = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q        <= S_IDLE;
            busy_q         <= '0;
            ptr_q          <= '0;
            grant_q        <= '0;
            cnt_q          <= '0;
            host_sel_q     <= 1'b0;
            host_rd_wr_n_q <= 1'b0;
            host_addr_q    <= '0;
            host_wdata_q   <= '0;
            req_ack_q      <= '0;
            req_timeout_q  <= '0;
            req_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            cnt_q          <= cnt_d;
            host_sel_q     <= host_sel_d;
            host_rd_wr_n_q <= host_rd_wr_n_d;
            host_addr_q    <= host_addr_d;
            host_wdata_q   <= host_wdata_d;
            req_ack_q      <= req_ack_d;
            req_timeout_q  <= req_timeout_d;
            req_rdata_q    <= req_rdata_d;
        end
    end

    assign o_req_busy       = busy_q;
    assign o_req_ack        = req_ack_q;
    assign o_req_timeout    = req_timeout_q;
    assign o_req_rdata      = req_rdata_q;
    assign o_host_sel       = host_sel_q;
    assign o_host_rd_wr_n   = host_rd_wr_n_q;
    assign o_host_byte_addr = host_addr_q;
    assign o_host_wdata     = host_wdata_q;
endmodule

// File: tb/tb_cmd_host_arbiter.sv
// tb/tb_cmd_host_arbiter.sv - self-checking bench for cmd_host_arbiter
module tb_cmd_host_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            srst = 1'b0;
    logic [N-1:0]    req_sel = '0;
    logic [N-1:0]    req_rd_wr_n;
    logic [N*AW-1:0] req_addr_flat;
    logic [N*DW-1:0] req_wdata_flat;
    logic [N-1:0]    req_busy, req_ack, req_timeout;
    logic [DW-1:0]   req_rdata;
    logic            host_sel, host_rd_wr_n;
    logic [AW-1:0]   host_addr;
    logic [DW-1:0]   host_wdata;
    logic            host_ack = 1'b0;
    logic [DW-1:0]   host_rdata = '0;

    logic [AW-1:0]   ta_addr [N];
    logic [DW-1:0]   ta_wd   [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign req_addr_flat[k*AW +: AW]  = ta_addr[k];
        assign req_wdata_flat[k*DW +: DW] = ta_wd[k];
    end

    cmd_host_arbiter #(
        .NUM_REQ(N), .HOST_ADDR_BITS(AW), .HOST_DATA_BITS(DW),
        .ACK_TIMEOUT_CLKS(64), .TIMEOUT_RDATA(32'hDEAD_BEEF)
    ) dut (
        .i_sysclk(clk), .i_srst(srst),
        .i_req_sel(req_sel), .i_req_rd_wr_n(req_rd_wr_n),
        .i_req_byte_addr(req_addr_flat), .i_req_wdata(req_wdata_flat),
        .o_req_busy(req_busy), .o_req_ack(req_ack), .o_req_timeout(req_timeout),
        .o_req_rdata(req_rdata),
        .o_host_sel(host_sel), .o_host_rd_wr_n(host_rd_wr_n),
        .o_host_byte_addr(host_addr), .o_host_wdata(host_wdata),
        .i_host_ack(host_ack), .i_host_rdata(host_rdata)
    );

    typedef struct {
        logic [3:0]  sel;
        logic        ack;
        logic [31:0] rdata;
        logic        e_sel;
        int          e_idx;
        logic [3:0]  e_ack;
        logic [31:0] e_rdata;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] sel, logic ack, logic [31:0] rd, logic e_sel,
                                int e_idx, logic [3:0] e_ack, logic [31:0] e_rdata,
                                logic [3:0] e_busy);
        vec_t v;
        v.sel = sel; v.ack = ack; v.rdata = rd; v.e_sel = e_sel; v.e_idx = e_idx;
        v.e_ack = e_ack; v.e_rdata = e_rdata; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".host_sel"}, 32'(host_sel), 32'd0);
        chk({tag, ".host_rd_wr_n"}, 32'(host_rd_wr_n), 32'd0);
        chk({tag, ".host_addr"}, host_addr, 32'd0);
        chk({tag, ".host_wdata"}, host_wdata, 32'd0);
        chk({tag, ".req_ack"}, 32'(req_ack), 32'd0);
        chk({tag, ".req_timeout"}, 32'(req_timeout), 32'd0);
        chk({tag, ".req_rdata"}, req_rdata, 32'd0);
        chk({tag, ".busy"}, 32'(req_busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        req_sel = '0; host_ack = 1'b0; host_rdata = '0;
        srst = 1'b1;
        step();
        step();
        chk_zero(tag);
        srst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            string n;
            n = $sformatf("%s[%0d]", tag, i);
            chk({n, ".host_sel"}, 32'(host_sel), 32'(vecs[i].e_sel));
            if (vecs[i].e_sel) begin
                chk({n, ".host_addr"}, host_addr, ta_addr[vecs[i].e_idx]);
                chk({n, ".host_rd_wr_n"}, 32'(host_rd_wr_n), 32'(req_rd_wr_n[vecs[i].e_idx]));
                chk({n, ".host_wdata"}, host_wdata, ta_wd[vecs[i].e_idx]);
            end
            chk({n, ".req_ack"}, 32'(req_ack), 32'(vecs[i].e_ack));
            chk({n, ".req_timeout"}, 32'(req_timeout), 32'd0);
            if (vecs[i].e_ack != 4'b0) begin
                chk({n, ".req_rdata"}, req_rdata, vecs[i].e_rdata);
            end
            chk({n, ".busy"}, 32'(req_busy), 32'(vecs[i].e_busy));
            req_sel = vecs[i].sel; host_ack = vecs[i].ack; host_rdata = vecs[i].rdata;
            step();
        end
        req_sel = '0; host_ack = 1'b0; host_rdata = '0;
        vecs.delete();
    endtask

    initial begin
        logic early;
        req_rd_wr_n = 4'b0101;
        for (int k = 0; k < N; k++) begin
            ta_addr[k] = 32'h0100_0004 + 32'(k << 8);
            ta_wd[k]   = 32'hC0DE_0000 + 32'(k);
        end

        // Single read from req0
        do_reset("reset0");
        vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 1, 32'h1234_5678, 0, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 32'h1234_5678, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        run_table("single");

        // Contention: all four at once, then req1 + req3
        do_reset("reset1");
        vecs.push_back(mk(4'b1111, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b1111));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 4'b0000, 0, 4'b1111));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0000, 0, 0, 4'b0000, 0, 4'b1111));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 32'hA0A0_0000, 4'b1110));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 1, 4'b0000, 0, 4'b1110));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0001, 0, 0, 4'b0000, 0, 4'b1110));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0010, 32'hA0A0_0001, 4'b1100));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 2, 4'b0000, 0, 4'b1100));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0002, 0, 0, 4'b0000, 0, 4'b1100));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0100, 32'hA0A0_0002, 4'b1000));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 3, 4'b0000, 0, 4'b1000));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0003, 0, 0, 4'b0000, 0, 4'b1000));
        vecs.push_back(mk(4'b1010, 0, 0, 0, 0, 4'b1000, 32'hA0A0_0003, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b1010));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 1, 4'b0000, 0, 4'b1010));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0004, 0, 0, 4'b0000, 0, 4'b1010));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0010, 32'hA0A0_0004, 4'b1000));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 3, 4'b0000, 0, 4'b1000));
        vecs.push_back(mk(4'b0000, 1, 32'hA0A0_0005, 0, 0, 4'b0000, 0, 4'b1000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b1000, 32'hA0A0_0005, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        run_table("contend");

        // Fairness: req0 re-requests on its ack while req2 waits; then a stale ack
        do_reset("reset2");
        vecs.push_back(mk(4'b0101, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0101));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 4'b0000, 0, 4'b0101));
        vecs.push_back(mk(4'b0000, 1, 32'hF0F0_0000, 0, 0, 4'b0000, 0, 4'b0101));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 0, 4'b0001, 32'hF0F0_0000, 4'b0100));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 2, 4'b0000, 0, 4'b0101));
        vecs.push_back(mk(4'b0000, 1, 32'hF0F0_0001, 0, 0, 4'b0000, 0, 4'b0101));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0100, 32'hF0F0_0001, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 1, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 1, 32'hF0F0_0002, 0, 0, 4'b0000, 0, 4'b0001));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0001, 32'hF0F0_0002, 4'b0000));
        vecs.push_back(mk(4'b0000, 1, 32'hBAD0_BAD0, 0, 0, 4'b0000, 0, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 4'b0000));
        run_table("fair");
        chk("stale.rdata_hold", req_rdata, 32'hF0F0_0002);

        // Timeout on req1 write, then ack on the terminal-count cycle
        do_reset("reset3");
        req_sel = 4'b0010; step(); req_sel = '0; step();
        chk("to.host_sel", 32'(host_sel), 32'd1);
        chk("to.host_rd_wr_n", 32'(host_rd_wr_n), 32'd0);
        chk("to.host_addr", host_addr, 32'h0100_0104);
        chk("to.host_wdata", host_wdata, 32'hC0DE_0001);
        early = 1'b0;
        for (int i = 0; i < 63; i++) begin
            step();
            if (req_ack != 4'b0 || host_sel) early = 1'b1;
        end
        chk("to.no_early_ack", 32'(early), 32'd0);
        step();
        chk("to.req_ack", 32'(req_ack), 32'b0010);
        chk("to.req_timeout", 32'(req_timeout), 32'b0010);
        chk("to.req_rdata", req_rdata, 32'hDEAD_BEEF);
        chk("to.busy", 32'(req_busy), 32'd0);
        req_sel = 4'b0010; step(); req_sel = '0;
        chk("tc.busy", 32'(req_busy), 32'b0010);
        step();
        chk("tc.host_sel", 32'(host_sel), 32'd1);
        early = 1'b0;
        for (int i = 0; i < 63; i++) begin
            step();
            if (req_ack != 4'b0 || req_timeout != 4'b0) early = 1'b1;
        end
        chk("tc.no_early_ack", 32'(early), 32'd0);
        host_ack = 1'b1; host_rdata = 32'h6363_6363; step(); host_ack = 1'b0;
        chk("tc.req_ack", 32'(req_ack), 32'b0010);
        chk("tc.req_timeout", 32'(req_timeout), 32'd0);
        chk("tc.req_rdata", req_rdata, 32'h6363_6363);

        // Repeated pulse on req2 while busy/in flight is ignored
        do_reset("reset4");
        req_sel = 4'b0100; step();
        ta_addr[2] = 32'h5555_AAA0; req_sel = 4'b0100; step();
        req_sel = 4'b0100;
        chk("dup.host_sel", 32'(host_sel), 32'd1);
        chk("dup.host_addr", host_addr, 32'h0100_0204);
        step();
        req_sel = '0; host_ack = 1'b1; host_rdata = 32'h2222_0000; step(); host_ack = 1'b0;
        chk("dup.req_ack", 32'(req_ack), 32'b0100);
        chk("dup.req_rdata", req_rdata, 32'h2222_0000);
        chk("dup.busy", 32'(req_busy), 32'd0);
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (req_ack != 4'b0 || host_sel || req_busy != 4'b0) early = 1'b1;
        end
        chk("dup.single_ack", 32'(early), 32'd0);
        ta_addr[2] = 32'h0100_0204;

        // Reset during WAIT_ACK abandons the transaction
        do_reset("reset5");
        req_sel = 4'b1000; step(); req_sel = '0; step();
        chk("mrst.host_sel", 32'(host_sel), 32'd1);
        step(); step();
        srst = 1'b1; step();
        chk_zero("mrst");
        srst = 1'b0; host_ack = 1'b1; host_rdata = 32'h7777_7777; step(); host_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mrst.after[%0d].req_ack", i), 32'(req_ack), 32'd0);
            chk($sformatf("mrst.after[%0d].host_sel", i), 32'(host_sel), 32'd0);
            chk($sformatf("mrst.after[%0d].busy", i), 32'(req_busy), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_host_arbiter.md
Name: cmd_host_arbiter

Overview:
Round-robin arbiter that shares the single host port of the command-bus master between NUM_REQ independent requesters (e.g. UART debug bridge, Ethernet control, local sequencer).
- Latches one pending transaction per requester and issues them one at a time to the master's host port.
- Returns ack and read data to the originating requester only.
- Supplies its own ack timeout, because the master silently drops un-acked transactions.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
HOST_ADDR_BITS, 32, host byte-address width
HOST_DATA_BITS, 32, host data width
ACK_TIMEOUT_CLKS, 64, cycles in WAIT_ACK before a transaction is abandoned; must exceed the master's slave-ack timeout
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
i_sysclk  in  1  system clock; only clock
i_srst  in  1  synchronous active-high reset
i_req_sel  in  NUM_REQ  per-requester one-cycle request pulse
i_req_rd_wr_n  in  NUM_REQ  1 = read, 0 = write
i_req_byte_addr  in  NUM_REQ*HOST_ADDR_BITS  flattened; requester k at [k*HOST_ADDR_BITS +: HOST_ADDR_BITS]
i_req_wdata  in  NUM_REQ*HOST_DATA_BITS  flattened write data
o_req_busy  out  NUM_REQ  request pending or in flight
o_req_ack  out  NUM_REQ  one-cycle completion pulse
o_req_timeout  out  NUM_REQ  one-cycle pulse, coincident with o_req_ack, when completion is due to timeout
o_req_rdata  out  HOST_DATA_BITS  shared read data; valid only with an o_req_ack bit
o_host_sel  out  1  one-cycle request pulse to master
o_host_rd_wr_n  out  1  to master
o_host_byte_addr  out  HOST_ADDR_BITS  to master
o_host_wdata  out  HOST_DATA_BITS  to master
i_host_ack  in  1  master ack pulse
i_host_rdata  in  HOST_DATA_BITS  master read data, valid with i_host_ack

Behaviour:
- Reset: all outputs 0; pending bits cleared; round-robin pointer = 0; state IDLE; timeout counter 0.
- Reset mid-transaction abandons it. No ack is issued for it.

Capture:
- i_req_sel[k] while busy[k] = 0: capture rd_wr_n, addr and wdata into holding register k; busy[k] = 1 from the next cycle.
- i_req_sel[k] while busy[k] = 1: ignored. Holding register is not modified.

FSM:
- IDLE: if any busy-and-not-in-flight bit is set, grant the lowest index at or after the RR pointer (wrapping modulo NUM_REQ).
  - Register the granted holding data onto the o_host_* outputs and pulse o_host_sel for exactly 1 cycle.
  - Store the grant index; go to WAIT_ACK.
- WAIT_ACK: counter increments each cycle.
  - i_host_ack = 1: next cycle o_req_ack[grant] = 1 and o_req_rdata = i_host_rdata (TIMEOUT_RDATA is not used); clear busy[grant]; RR pointer = grant+1 mod NUM_REQ; go to IDLE.
  - Else, counter == ACK_TIMEOUT_CLKS-1: same completion, but o_req_timeout[grant] = 1 and o_req_rdata = TIMEOUT_RDATA.
  - Ack on the terminal-count cycle: treated as a normal ack, no timeout.
- i_host_ack while in IDLE: ignored (stale ack).

Timing and output rules:
- Latency: request pulse at cycle t (idle arbiter, no contention) gives o_host_sel at t+2. Host ack at cycle c gives o_req_ack at c+1. The earliest next o_host_sel is c+2.
- o_host_rd_wr_n, o_host_byte_addr and o_host_wdata hold their value until the next grant.
- o_req_rdata holds its value between acks.
- A requester may re-request in the cycle o_req_ack is seen, since busy is already 0.
- At most one bit of o_req_ack is set in any cycle.
- o_host_sel is never asserted while in WAIT_ACK.

Test Plan:
- Single read: req0 rd addr 0x0100_0004; master acks 3 cycles after o_host_sel with 0x1234_5678 -> o_host_sel at t+2 with addr 0x0100_0004, rd_wr_n = 1; o_req_ack[0] = 1 with rdata 0x1234_5678 one cycle after the host ack; busy[0] back to 0.
- Contention: req0..req3 all pulse in the same cycle, pointer 0 -> host grants in order 0,1,2,3. Next round with req1 and req3 pending -> 1, then 3. Each requester gets exactly one ack.
- Fairness: req0 re-requests immediately after every ack while req2 is pending -> req2 is granted before req0's second grant.
- Timeout: req1 write, master never acks -> after 64 cycles in WAIT_ACK, o_req_ack[1] = o_req_timeout[1] = 1, rdata = 0xDEAD_BEEF. Ack on cycle 63 of WAIT_ACK -> normal ack, timeout = 0.
- Protocol edges: second pulse on req2 while busy -> ignored, original address issued, one ack. Stale i_host_ack in IDLE -> no o_req_ack. i_srst asserted during WAIT_ACK -> all outputs 0, busy cleared, no ack.
